// File: rtl/bus_pack_v1_0.sv
// Packs `ratio` narrow words (first word in lane 0) into one wide word, with flush for partial words.
// out_valid follows the final accept by one cycle; in_ready drops while a word waits for out_ready.
module bus_pack_v1_0 #(
    parameter int in_width = 8,
    parameter int ratio    = 4
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [in_width-1:0]          in_data,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic                         flush,
    output logic [in_width*ratio-1:0]    out_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [$clog2(ratio):0]       out_count
);

    localparam int cnt_w = $clog2(ratio) + 1;

    typedef enum logic {
        fill_st,
        hold_st
    } state_t;

    state_t                      state;
    state_t                      state_nxt;
    logic [cnt_w-1:0]            cnt;
    logic [cnt_w-1:0]            cnt_nxt;
    logic [in_width*ratio-1:0]   data_q;
    logic [in_width*ratio-1:0]   data_nxt;
    logic                        in_acc;
    logic                        out_acc;

    // in_ready is held low while reset is asserted, even though the state is already FILL.
    assign in_ready  = (state == fill_st) && reset;
    assign out_valid = (state == hold_st);
    assign in_acc    = in_valid && in_ready;
    assign out_acc   = out_valid && out_ready;
    assign out_data  = data_q;
    assign out_count = cnt;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        data_nxt  = data_q;
        case (state)
            fill_st: begin
                if (in_acc) begin
                    for (int k = 0; k < ratio; k++) begin
                        if (cnt == cnt_w'(k)) begin
                            data_nxt[k*in_width +: in_width] = in_data;
                        end
                    end
                    cnt_nxt = cnt + cnt_w'(1);
                    if (cnt == cnt_w'(ratio - 1) || flush) begin
                        state_nxt = hold_st;
                    end
                end else if (flush && cnt != '0) begin
                    state_nxt = hold_st;
                end
            end
            hold_st: begin
                // Clearing on drain keeps unused lanes zero for the next partial word.
                if (out_acc) begin
                    state_nxt = fill_st;
                    cnt_nxt   = '0;
                    data_nxt  = '0;
                end
            end
            default: begin
                state_nxt = fill_st;
                cnt_nxt   = '0;
                data_nxt  = '0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state  <= fill_st;
            cnt    <= '0;
            data_q <= '0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            data_q <= data_nxt;
        end
    end

endmodule
